// File: rtl/contador_modulo15.sv
// contador_modulo15: free-running modulo-MODULUS up-counter. IMPL selects an adder or a decode table.
// Define CONTADOR_MODULO15_TC_EN to add the registered terminal-count output tc.
module contador_modulo15 #(
   parameter int WIDTH   = 4,
   parameter int MODULUS = 15,
   parameter int IMPL    = 0
) (
   input  logic             clk,
   input  logic             rst,
`ifdef CONTADOR_MODULO15_TC_EN
   output logic [WIDTH-1:0] cont,
   output logic             tc
`else
   output logic [WIDTH-1:0] cont
`endif
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] cont_q;
   logic [WIDTH-1:0] cont_d;

   generate
      if (IMPL == 1) begin : g_table
         // Each legal state decodes to its successor.
         // Anything left unmatched (the last state or an illegal one) falls back to 0.
         always_comb begin
            cont_d = '0;
            for (int s = 0; s < MODULUS - 1; s++) begin
               if (cont_q == WIDTH'(s)) begin
                  cont_d = WIDTH'(s + 1);
               end
            end
         end
      end else begin : g_adder
         // ">=" rather than "==" so that illegal states also wrap to 0.
         always_comb begin
            cont_d = (cont_q >= LAST) ? '0 : cont_q + WIDTH'(1);
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cont_q <= '0;
      end else begin
         cont_q <= cont_d;
      end
   end

   assign cont = cont_q;

`ifdef CONTADOR_MODULO15_TC_EN
   logic tc_q;

   // tc is derived from the next state, so it rises in the same cycle that cont shows LAST.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tc_q <= 1'b0;
      end else begin
         tc_q <= (cont_d == LAST);
      end
   end

   assign tc = tc_q;
`endif

endmodule

// File: tb/tb_contador_modulo15.sv
// Scoreboard bench: runs the IMPL=0 and IMPL=1 counters side by side against hand-computed sequences.
// The stimulus pushes the expected count into a queue, and a monitor pops and compares the queue entries.
module tb_contador_modulo15;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] cont0;
   logic [3:0] cont1;
   logic       tc0;
   logic       tc1;

   int         checks = 0;
   int         errors = 0;
   logic [3:0] exp_q[$];
   event       chk_ev;

   contador_modulo15 #(.WIDTH(4), .MODULUS(15), .IMPL(0)) dut0 (
      .clk  (clk),
      .rst  (rst),
`ifdef CONTADOR_MODULO15_TC_EN
      .cont (cont0),
      .tc   (tc0)
`else
      .cont (cont0)
`endif
   );

   contador_modulo15 #(.WIDTH(4), .MODULUS(15), .IMPL(1)) dut1 (
      .clk  (clk),
      .rst  (rst),
`ifdef CONTADOR_MODULO15_TC_EN
      .cont (cont1),
      .tc   (tc1)
`else
      .cont (cont1)
`endif
   );

`ifndef CONTADOR_MODULO15_TC_EN
   assign tc0 = 1'b0;
   assign tc1 = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic compare(input string name, input logic [3:0] act, input logic [3:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d at t=%0t", name, act, req, $time);
      end
   endtask

   // The monitor samples at the falling edge, or on chk_ev for the checks made between clock edges.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk or chk_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("t=%0t rst=%0b expect=%0d impl0=%0d impl1=%0d tc0=%0b tc1=%0b",
                     $time, rst, e, cont0, cont1, tc0, tc1);
            compare("cont_impl0", cont0, e);
            compare("cont_impl1", cont1, e);
`ifdef CONTADOR_MODULO15_TC_EN
            compare("tc_impl0", {3'b000, tc0}, {3'b000, (e == 4'd14)});
            compare("tc_impl1", {3'b000, tc1}, {3'b000, (e == 4'd14)});
`endif
         end
      end
   end

   // The rst value is set 1 ns after the edge, so the edge itself was taken with the previous rst.
   task automatic cyc(input logic r, input logic [3:0] e);
      @(posedge clk);
      #1;
      rst = r;
      exp_q.push_back(e);
   endtask

   initial begin
      int seq32 [32];
      seq32 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 0,
                1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 0, 1, 2};

      #2 rst = 1'b0;
      // Reset hold for 5 clock cycles.
      repeat (5) cyc(1'b0, 4'd0);
      // This edge is still taken under reset.
      cyc(1'b1, 4'd0);
      foreach (seq32[i]) cyc(1'b1, 4'(seq32[i]));

      // Count up to 9, then assert reset between edges.
      for (int v = 3; v <= 9; v++) cyc(1'b1, 4'(v));
      @(negedge clk);
      #2;
      rst = 1'b0;
      exp_q.push_back(4'd0);
      #1 ->chk_ev;
      cyc(1'b1, 4'd0);
      cyc(1'b1, 4'd1);
      for (int v = 2; v <= 5; v++) cyc(1'b1, 4'(v));

      // Force the illegal state 15, then check recovery to 0 and continued counting.
      @(negedge clk);
      #2;
      force dut0.cont_q = 4'd15;
      force dut1.cont_q = 4'd15;
      #1;
      release dut0.cont_q;
      release dut1.cont_q;
      cyc(1'b1, 4'd0);
      cyc(1'b1, 4'd1);
      cyc(1'b1, 4'd2);
      cyc(1'b1, 4'd3);

      // Run 45 cycles from reset, which spans three full periods with three terminal counts.
      cyc(1'b0, 4'd0);
      cyc(1'b0, 4'd0);
      cyc(1'b1, 4'd0);
      for (int i = 1; i <= 45; i++) cyc(1'b1, 4'(i % 15));

      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
